// File: rtl/mem_access_unit.sv
// Memory-stage access sequencer: one load/store at a time through a req/ack data-memory port,
// with store lane formatting, load extension, stall generation and fault reporting.
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memValid,
   input  logic [6:0]  memOpcode,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] storeData,
   input  logic [4:0]  destAddr,
   output logic        dmemReq,
   output logic        dmemWe,
   output logic [31:0] dmemAddr,
   output logic [31:0] dmemWdata,
   output logic [3:0]  dmemWstrb,
   input  logic        dmemAck,
   input  logic [31:0] dmemRdata,
   output logic        memLocker,
   output logic        isLWDone,
   output logic        wbValid,
   output logic [4:0]  wbAddr,
   output logic [31:0] wbData,
   output logic        memFault
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam int         CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam bit         TMO_EN   = (TIMEOUT > 0);
   localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_r;
   logic          is_load_r;
   logic [2:0]    funct3_r;
   logic [1:0]    off_r;
   logic [CW-1:0] cnt_r;

   logic          is_load_s;
   logic          is_store_s;
   logic          mem_op_s;
   logic          f3_ok_s;
   logic          misalign_s;
   logic          fault_s;
   logic          tmo_hit_s;
   logic [31:0]   ld_data_s;

   function automatic logic [31:0] fmt_store_data(input logic [2:0] f3, input logic [31:0] d);
      case (f3)
         3'd0:    return {4{d[7:0]}};
         3'd1:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [3:0] fmt_store_strb(input logic [2:0] f3, input logic [1:0] off);
      case (f3)
         3'd0:    return 4'b0001 << off;
         3'd1:    return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] d);
      logic [31:0] sh;
      sh = d >> {off, 3'b000};
      case (f3)
         3'd0:    return {{24{sh[7]}}, sh[7:0]};
         3'd1:    return {{16{sh[15]}}, sh[15:0]};
         3'd4:    return {24'd0, sh[7:0]};
         3'd5:    return {16'd0, sh[15:0]};
         default: return d;
      endcase
   endfunction

   // Decode the incoming op and classify it as legal or faulting.
   always_comb begin
      is_load_s  = (memOpcode == OP_LOAD);
      is_store_s = (memOpcode == OP_STORE);
      mem_op_s   = memValid && (is_load_s || is_store_s);
      case (funct3)
         3'd0, 3'd1, 3'd2: f3_ok_s = 1'b1;
         3'd4, 3'd5:       f3_ok_s = is_load_s;
         default:          f3_ok_s = 1'b0;
      endcase
      case (funct3)
         3'd2:       misalign_s = (addr[1:0] != 2'b00);
         3'd1, 3'd5: misalign_s = addr[0];
         default:    misalign_s = 1'b0;
      endcase
      fault_s = !f3_ok_s || misalign_s;
   end

   assign tmo_hit_s = TMO_EN && (cnt_r == TMO_LAST);
   assign ld_data_s = fmt_load(funct3_r, off_r, dmemRdata);

   // Stall the pipeline while an op waits for acceptance or for its memory ack.
   always_comb begin
      if (state_r == ST_REQ) begin
         memLocker = 1'b0;
      end else if ((state_r == ST_IDLE) && mem_op_s) begin
         memLocker = 1'b0;
      end else begin
         memLocker = 1'b1;
      end
   end

   // Access sequencer: accept, request, and one-cycle completion with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         is_load_r <= 1'b0;
         funct3_r  <= 3'd0;
         off_r     <= 2'd0;
         cnt_r     <= '0;
         dmemReq   <= 1'b0;
         dmemWe    <= 1'b0;
         dmemAddr  <= 32'd0;
         dmemWdata <= 32'd0;
         dmemWstrb <= 4'd0;
         isLWDone  <= 1'b0;
         wbValid   <= 1'b0;
         wbAddr    <= 5'd0;
         wbData    <= 32'd0;
         memFault  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               isLWDone <= 1'b0;
               wbValid  <= 1'b0;
               memFault <= 1'b0;
               dmemReq  <= 1'b0;
               if (mem_op_s) begin
                  is_load_r <= is_load_s;
                  funct3_r  <= funct3;
                  off_r     <= addr[1:0];
                  wbAddr    <= destAddr;
                  dmemWe    <= is_store_s;
                  dmemAddr  <= {addr[31:2], 2'b00};
                  dmemWdata <= fmt_store_data(funct3, storeData);
                  dmemWstrb <= fmt_store_strb(funct3, addr[1:0]);
                  cnt_r     <= '0;
                  if (fault_s) begin
                     // Faulting ops skip the bus entirely but still retire through DONE.
                     state_r  <= ST_DONE;
                     memFault <= 1'b1;
                     isLWDone <= is_load_s;
                  end else begin
                     state_r <= ST_REQ;
                     dmemReq <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (dmemAck) begin
                  dmemReq  <= 1'b0;
                  state_r  <= ST_DONE;
                  isLWDone <= is_load_r;
                  wbValid  <= is_load_r && (wbAddr != 5'd0);
                  if (is_load_r) begin
                     wbData <= ld_data_s;
                  end
               end else if (tmo_hit_s) begin
                  dmemReq  <= 1'b0;
                  state_r  <= ST_DONE;
                  memFault <= 1'b1;
                  isLWDone <= is_load_r;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            ST_DONE: begin
               isLWDone <= 1'b0;
               wbValid  <= 1'b0;
               memFault <= 1'b0;
               state_r  <= ST_IDLE;
            end
            default: begin
               dmemReq  <= 1'b0;
               isLWDone <= 1'b0;
               wbValid  <= 1'b0;
               memFault <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access sequencer between the ALU_MEM pipeline register and the data memory port. Accepts one load or store at a time, performs a req/ack handshake of variable latency with data memory, formats store byte lanes and sign/zero-extends load data, and drives the stall and `isLWDone` signals that the hazard detect unit consumes. It answers the hazard unit's load-use and branch-forward logic: it produces the load-completion pulse and the memory-stage lock that the hazard unit waits on.

## Interface
- `TIMEOUT`, 16: cycles to wait for `dmemAck` before aborting; 0 disables the timeout.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `memValid` in 1: ALU_MEM holds a valid memory operation.
- `memOpcode` in 7: load `0000011` or store `0100011`; any other value is ignored.
- `funct3` in 3: 0=B, 1=H, 2=W, 4=BU, 5=HU.
- `addr` in 32: effective address.
- `storeData` in 32: rs2 value, LSB-aligned.
- `destAddr` in 5: load destination register.
- `dmemReq` out 1, `dmemWe` out 1, `dmemAddr` out 32 (word-aligned, `addr[31:2],2'b00`), `dmemWdata` out 32, `dmemWstrb` out 4.
- `dmemAck` in 1, `dmemRdata` in 32.
- `memLocker` out 1: 1 = pipeline may advance, 0 = stall (same polarity as the other lockers).
- `isLWDone` out 1: one-cycle pulse when a load completes.
- `wbValid` out 1, `wbAddr` out 5, `wbData` out 32: load write-back.
- `memFault` out 1: one-cycle pulse on a misaligned access, an illegal `funct3`, or a timeout.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: a memory op is `memValid` with a load or store opcode. When one is present, latch `addr`, `funct3`, `destAddr`, the formatted store data and strobe, and the opcode.
  - Legal op: go to REQ.
  - Misaligned op (W with `addr[1:0]`≠0, H/HU with `addr[0]`≠0) or illegal `funct3` (load 3/6/7, store ≥3): go to DONE with the fault flag set and issue no request.
- REQ: `dmemReq`=1, with `dmemWe`, `dmemAddr`, `dmemWdata` and `dmemWstrb` stable from latched registers.
  - On a rising edge with `dmemAck`=1: capture `dmemRdata`, drop `dmemReq`, go to DONE.
  - The timeout counter resets on entry to REQ and increments each REQ cycle. When it reaches `TIMEOUT`-1 with no ack: drop `dmemReq`, go to DONE with the fault flag set.
- DONE: lasts one cycle, then IDLE unconditionally.
  - Faulted op: `memFault`=1.
  - Load without fault: `isLWDone`=1, and `wbValid`=1 unless `destAddr`=0.
  - `wbAddr`/`wbData` hold the latched values. A faulted load still pulses `isLWDone` but `wbValid`=0.
- Store formatting: B replicates byte ×4 with strobe `0001<<addr[1:0]`; H replicates half ×2 with strobe `0011<<addr[1:0]`; W uses strobe `1111`.
- Load formatting: select lane by `addr[1:0]`; B/H sign-extend, BU/HU zero-extend, W passes through.
- `memLocker` (combinational) = 0 when state=REQ, or state=IDLE with a memory op present. It is 1 in DONE and otherwise.
- `dmemAck` in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, `dmemReq`=0, `dmemWe`=0, `dmemAddr`=0, `dmemWdata`=0, `dmemWstrb`=0, `isLWDone`=0, `wbValid`=0, `wbAddr`=0, `wbData`=0, `memFault`=0. `memLocker` follows its combinational rule (1 when `memValid`=0).
- `dmemReq` is registered: asserted the cycle after acceptance, held until the ack edge.
- Minimum latency with ack in the first REQ cycle: accept at edge E0, REQ during cycle 1, ack sampled at E1, DONE during cycle 2. Total of 3 cycles with `memLocker`=0 for cycles 0–1.
- Each extra wait cycle adds one stall cycle.
- Fault path: accept at E0, DONE in cycle 1, no `dmemReq`.
- Timeout with `TIMEOUT`=T: `dmemReq` is high for exactly T cycles, then DONE.
- Reset asserted mid-REQ: `dmemReq` drops immediately and asynchronously. An ack arriving after reset release is ignored.
- During DONE, `memValid` for the same instruction is still high. It is not re-accepted, because DONE always exits to IDLE and upstream advances on `memLocker`=1.

## Test plan
- LW from `0x100`, ack at first REQ cycle, `dmemRdata`=`0xDEADBEEF`, `destAddr`=5 -> `dmemReq` high 1 cycle; in DONE `isLWDone`=1, `wbValid`=1, `wbAddr`=5, `wbData`=`0xDEADBEEF`; `memLocker` low 2 cycles.
- LB at `0x103`, rdata `0x80FFFFFF` -> `wbData`=`0xFFFFFF80`; LBU at the same address -> `0x00000080`; LHU at `0x102` with rdata `0x8001xxxx` -> `0x00008001`.
- SB `storeData`=`0x000000AB` at `0x0102`, ack after 3 wait cycles -> `dmemWe`=1, `dmemWstrb`=`0100`, `dmemWdata`=`0xABABABAB`, `dmemAddr`=`0x100`; stall 5 cycles; `isLWDone` stays 0.
- LW at `0x101` -> no `dmemReq`; `memFault` and `isLWDone` pulse 1 cycle; `wbValid`=0.
- `TIMEOUT`=4, never ack -> `dmemReq` high exactly 4 cycles, then `memFault` pulse; a late ack in IDLE has no effect.
- `rst_n` low in REQ cycle 2 -> `dmemReq`=0 immediately; after release, a new LW completes normally; a load to x0 pulses `isLWDone` with `wbValid`=0.
